// File: rtl/frame_timing_pkg.sv
// frame_timing_pkg
//   Shared definitions for the frame timing generator: the 2-bit "active"
//   region codes, the counter width and the default raster timing constants.
//   No ports (package).
package frame_timing_pkg;

   // Wide enough for both the column (0..457) and row (0..311) counters.
   localparam int unsigned CNT_W = 9;

   typedef enum logic [1:0] {
      ACT_BLANK  = 2'b00,
      ACT_BORDER = 2'b10,
      ACT_VIEW   = 2'b11
   } active_e;

   localparam int unsigned DEF_H_TOTAL      = 458;
   localparam int unsigned DEF_V_TOTAL_NTSC = 262;
   localparam int unsigned DEF_V_TOTAL_PAL  = 312;
   localparam int unsigned DEF_HSYNC_START  = 11;
   localparam int unsigned DEF_HSYNC_END    = 34;
   localparam int unsigned DEF_VSYNC_START  = 4;
   localparam int unsigned DEF_VSYNC_END    = 8;
   localparam int unsigned DEF_H_BLANK_END  = 78;
   localparam int unsigned DEF_V_BLANK_END  = 10;
   localparam int unsigned DEF_PORT_X       = 130;
   localparam int unsigned DEF_PORT_W       = 256;
   localparam int unsigned DEF_PORT_Y_NTSC  = 64;
   localparam int unsigned DEF_PORT_Y_PAL   = 89;
   localparam int unsigned DEF_PORT_H       = 192;
   localparam int unsigned DEF_PRELOAD_LEAD = 8;
   localparam int unsigned DEF_ROW_LINES    = 12;

endpackage

// File: rtl/frame_counter.sv
// frame_counter
//   Column/row raster counters plus the frame-synchronous shadow copies of
//   the format and div2 controls.
//   Ports:
//     clk_i, rstn_i     pixel clock, asynchronous active-low reset
//     format_i, div2_i  raw controls, sampled only at the last pixel of a frame
//     col_o, row_o      current raster position
//     fmt_o, div2_o     shadow format (0 NTSC, 1 PAL) and div2 for this frame
module frame_counter
   import frame_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
   parameter int unsigned V_TOTAL_NTSC = DEF_V_TOTAL_NTSC,
   parameter int unsigned V_TOTAL_PAL  = DEF_V_TOTAL_PAL
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             format_i,
   input  logic             div2_i,
   output logic [CNT_W-1:0] col_o,
   output logic [CNT_W-1:0] row_o,
   output logic             fmt_o,
   output logic             div2_o
);

   localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] ROW_LAST_N  = CNT_W'(V_TOTAL_NTSC - 1);
   localparam logic [CNT_W-1:0] ROW_LAST_P  = CNT_W'(V_TOTAL_PAL - 1);

   logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
   logic             fmt_q, fmt_d, div2_q, div2_d;
   logic             col_end, row_end;

   always_comb begin
      col_end = (col_q == COL_LAST);
      // Frame length follows the shadow format, so a mid-frame format
      // change cannot stretch or cut the frame in progress.
      row_end = (row_q == (fmt_q ? ROW_LAST_P : ROW_LAST_N));
      col_d   = col_end ? '0 : col_q + 1'b1;
      row_d   = row_q;
      fmt_d   = fmt_q;
      div2_d  = div2_q;
      if (col_end) begin
         row_d = row_end ? '0 : row_q + 1'b1;
         if (row_end) begin
            fmt_d  = format_i;
            div2_d = div2_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         col_q  <= '0;
         row_q  <= '0;
         fmt_q  <= 1'b0;
         div2_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         fmt_q  <= fmt_d;
         div2_q <= div2_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign fmt_o  = fmt_q;
   assign div2_o = div2_q;

endmodule

// File: rtl/frame_timing_gen.sv
// frame_timing_gen
//   Video raster timing: syncs, blanking/border/viewport region, character
//   fetch strobes, character-row line counter and an optional lightpen latch.
//   Every output is registered and reflects the counter state one clock back.
//   Optional feature: define FRAME_TIMING_LIGHTPEN_EN to build the lightpen
//   synchroniser and latch; otherwise lp/lp_ack are ignored and lp_* read 0.
//   Ports:
//     clk, rstn                 pixel clock, asynchronous active-low reset
//     format, div2              0 NTSC / 1 PAL; 1 = 16-byte viewport
//     hsn, fsn                  active-low horizontal / frame sync
//     active                    00 blank, 10 border, 11 viewport
//     fetch, byte_idx, preload  character fetch strobe, byte index, first fetch
//     alpha_row, rowclear       line within character row, row wrap strobe
//     line_start, frame_start   col 0 / col 0 row 0 strobes
//     field                     toggles every frame
//     lp, lp_ack                lightpen input and acknowledge
//     lp_x, lp_y, lp_valid      captured lightpen viewport position
module frame_timing_gen
   import frame_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
   parameter int unsigned V_TOTAL_NTSC = DEF_V_TOTAL_NTSC,
   parameter int unsigned V_TOTAL_PAL  = DEF_V_TOTAL_PAL,
   parameter int unsigned HSYNC_START  = DEF_HSYNC_START,
   parameter int unsigned HSYNC_END    = DEF_HSYNC_END,
   parameter int unsigned VSYNC_START  = DEF_VSYNC_START,
   parameter int unsigned VSYNC_END    = DEF_VSYNC_END,
   parameter int unsigned H_BLANK_END  = DEF_H_BLANK_END,
   parameter int unsigned V_BLANK_END  = DEF_V_BLANK_END,
   parameter int unsigned PORT_X       = DEF_PORT_X,
   parameter int unsigned PORT_W       = DEF_PORT_W,
   parameter int unsigned PORT_Y_NTSC  = DEF_PORT_Y_NTSC,
   parameter int unsigned PORT_Y_PAL   = DEF_PORT_Y_PAL,
   parameter int unsigned PORT_H       = DEF_PORT_H,
   parameter int unsigned PRELOAD_LEAD = DEF_PRELOAD_LEAD,
   parameter int unsigned ROW_LINES    = DEF_ROW_LINES
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       format,
   input  logic       div2,
   output logic       hsn,
   output logic       fsn,
   output logic [1:0] active,
   output logic       fetch,
   output logic [4:0] byte_idx,
   output logic       preload,
   output logic [3:0] alpha_row,
   output logic       rowclear,
   output logic       line_start,
   output logic       frame_start,
   output logic       field,
   input  logic       lp,
   input  logic       lp_ack,
   output logic [7:0] lp_x,
   output logic [7:0] lp_y,
   output logic       lp_valid
);

   localparam logic [CNT_W-1:0] HS_S    = CNT_W'(HSYNC_START);
   localparam logic [CNT_W-1:0] HS_E    = CNT_W'(HSYNC_END);
   localparam logic [CNT_W-1:0] VS_S    = CNT_W'(VSYNC_START);
   localparam logic [CNT_W-1:0] VS_E    = CNT_W'(VSYNC_END);
   localparam logic [CNT_W-1:0] HB_E    = CNT_W'(H_BLANK_END);
   localparam logic [CNT_W-1:0] VB_E    = CNT_W'(V_BLANK_END);
   localparam logic [CNT_W-1:0] PX      = CNT_W'(PORT_X);
   localparam logic [CNT_W-1:0] PX_END  = CNT_W'(PORT_X + PORT_W);
   localparam logic [CNT_W-1:0] PY_N    = CNT_W'(PORT_Y_NTSC);
   localparam logic [CNT_W-1:0] PY_P    = CNT_W'(PORT_Y_PAL);
   localparam logic [CNT_W-1:0] PH      = CNT_W'(PORT_H);
   localparam logic [CNT_W-1:0] FETCH_X = CNT_W'(PORT_X - PRELOAD_LEAD);
   localparam logic [CNT_W-1:0] FETCH_W = CNT_W'(PORT_W);
   localparam logic [3:0]       AR_LAST = 4'(ROW_LINES - 1);

   logic [CNT_W-1:0] col, row, port_y, rel;
   logic             fmt, d2, vrow, hview, blank, fetch_col;

   logic             hsn_q, hsn_d, fsn_q, fsn_d;
   active_e          active_q, active_d;
   logic             fetch_q, fetch_d, preload_q, preload_d;
   logic [4:0]       byte_idx_q, byte_idx_d;
   logic [3:0]       alpha_q, alpha_d;
   logic             rowclear_q, rowclear_d;
   logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic             field_q, field_d;

   frame_counter #(
      .H_TOTAL      (H_TOTAL),
      .V_TOTAL_NTSC (V_TOTAL_NTSC),
      .V_TOTAL_PAL  (V_TOTAL_PAL)
   ) u_counter (
      .clk_i    (clk),
      .rstn_i   (rstn),
      .format_i (format),
      .div2_i   (div2),
      .col_o    (col),
      .row_o    (row),
      .fmt_o    (fmt),
      .div2_o   (d2)
   );

   always_comb begin
      port_y = fmt ? PY_P : PY_N;
      vrow   = (row >= port_y) && (row < port_y + PH);
      hview  = (col >= PX) && (col < PX_END);
      blank  = (col < HB_E) || (row < VB_E);
      // Fetch slots are PRELOAD_LEAD ahead of the viewport; steps are powers
      // of two so slot alignment and index come straight from rel's bits.
      rel       = col - FETCH_X;
      fetch_col = (col >= FETCH_X) && (rel < FETCH_W) &&
                  (d2 ? (rel[3:0] == '0) : (rel[2:0] == '0));

      hsn_d         = !((col >= HS_S) && (col < HS_E));
      fsn_d         = !((row >= VS_S) && (row < VS_E));
      active_d      = blank ? ACT_BLANK : ((vrow && hview) ? ACT_VIEW : ACT_BORDER);
      fetch_d       = vrow && fetch_col;
      byte_idx_d    = fetch_d ? (d2 ? 5'(rel >> 4) : 5'(rel >> 3)) : '0;
      preload_d     = fetch_d && (rel == '0);
      line_start_d  = (col == '0);
      frame_start_d = line_start_d && (row == '0);
      field_d       = field_q ^ frame_start_d;

      alpha_d    = alpha_q;
      rowclear_d = 1'b0;
      if (line_start_d) begin
         if (!vrow) begin
            alpha_d = '0;
         end else if (alpha_q == AR_LAST) begin
            alpha_d    = '0;
            rowclear_d = 1'b1;
         end else begin
            alpha_d = alpha_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hsn_q         <= 1'b1;
         fsn_q         <= 1'b1;
         active_q      <= ACT_BLANK;
         fetch_q       <= 1'b0;
         byte_idx_q    <= '0;
         preload_q     <= 1'b0;
         alpha_q       <= '0;
         rowclear_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         field_q       <= 1'b0;
      end else begin
         hsn_q         <= hsn_d;
         fsn_q         <= fsn_d;
         active_q      <= active_d;
         fetch_q       <= fetch_d;
         byte_idx_q    <= byte_idx_d;
         preload_q     <= preload_d;
         alpha_q       <= alpha_d;
         rowclear_q    <= rowclear_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         field_q       <= field_d;
      end
   end

   assign hsn         = hsn_q;
   assign fsn         = fsn_q;
   assign active      = active_q;
   assign fetch       = fetch_q;
   assign byte_idx    = byte_idx_q;
   assign preload     = preload_q;
   assign alpha_row   = alpha_q;
   assign rowclear    = rowclear_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign field       = field_q;

`ifdef FRAME_TIMING_LIGHTPEN_EN
   logic [2:0]       lp_sync_q;
   logic             lp_edge, lp_valid_q, lp_valid_d;
   logic [7:0]       lp_x_q, lp_x_d, lp_y_q, lp_y_d;
   logic [CNT_W-1:0] dx, dy;

   // Position is taken from the counter state the edge is seen in, which is
   // the state active_d decodes, so the viewport test uses active_d.
   always_comb begin
      lp_edge    = lp_sync_q[1] & ~lp_sync_q[2];
      dx         = col - PX;
      dy         = row - port_y;
      lp_valid_d = lp_valid_q;
      lp_x_d     = lp_x_q;
      lp_y_d     = lp_y_q;
      if (lp_ack) begin
         lp_valid_d = 1'b0;
      end else if (lp_edge && !lp_valid_q && (active_d == ACT_VIEW)) begin
         lp_valid_d = 1'b1;
         lp_x_d     = d2 ? 8'(dx >> 1) : 8'(dx);
         lp_y_d     = 8'(dy);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lp_sync_q  <= '0;
         lp_valid_q <= 1'b0;
         lp_x_q     <= '0;
         lp_y_q     <= '0;
      end else begin
         lp_sync_q  <= {lp_sync_q[1:0], lp};
         lp_valid_q <= lp_valid_d;
         lp_x_q     <= lp_x_d;
         lp_y_q     <= lp_y_d;
      end
   end

   assign lp_x     = lp_x_q;
   assign lp_y     = lp_y_q;
   assign lp_valid = lp_valid_q;
`else
   logic unused_lp;
   assign unused_lp = lp ^ lp_ack;
   assign lp_x      = '0;
   assign lp_y      = '0;
   assign lp_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_frame_timing_gen.sv
module tb_frame_timing_gen;

   // Horizontal timing at defaults; vertical shrunk so each frame is short.
   localparam int LINE = 458;
   localparam int VN   = 30;
   localparam int VP   = 36;
   localparam int NF   = VN * LINE;
   localparam int NP   = VP * LINE;
   localparam int F2   = NF;
   localparam int F3   = 2 * NF;
   localparam int F4   = F3 + NP;
`ifdef FRAME_TIMING_LIGHTPEN_EN
   localparam int LP = 1;
`else
   localparam int LP = 0;
`endif

   logic       clk = 1'b0, rstn = 1'b0, format = 1'b0, div2 = 1'b0;
   logic       lp = 1'b0, lp_ack = 1'b0;
   logic       hsn, fsn, fetch, preload, rowclear, line_start, frame_start, field, lp_valid;
   logic [1:0] active;
   logic [4:0] byte_idx;
   logic [3:0] alpha_row;
   logic [7:0] lp_x, lp_y;

   frame_timing_gen #(
      .V_TOTAL_NTSC (VN),
      .V_TOTAL_PAL  (VP),
      .PORT_Y_NTSC  (12),
      .PORT_Y_PAL   (16),
      .PORT_H       (12),
      .ROW_LINES    (4)
   ) dut (
      .clk (clk), .rstn (rstn), .format (format), .div2 (div2),
      .hsn (hsn), .fsn (fsn), .active (active),
      .fetch (fetch), .byte_idx (byte_idx), .preload (preload),
      .alpha_row (alpha_row), .rowclear (rowclear),
      .line_start (line_start), .frame_start (frame_start), .field (field),
      .lp (lp), .lp_ack (lp_ack), .lp_x (lp_x), .lp_y (lp_y), .lp_valid (lp_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         row;
      int         col;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0, fails = 0, cyc = 0;
   int   hs_low = 0, fs_low = 0, fetch_n = 0, rc_n = 0, fs_n = 0, alpha_bad = 0;
   bit   track_alpha = 1'b1;

   function automatic logic [12:0] pk(input logic hs, input logic fs, input logic [1:0] act,
                                      input logic fe, input logic [4:0] bi, input logic pre,
                                      input logic ls, input logic fst);
      return {hs, fs, act, fe, bi, pre, ls, fst};
   endfunction

   function automatic logic [12:0] actual();
      return {hsn, fsn, active, fetch, byte_idx, preload, line_start, frame_start};
   endfunction

   function automatic int ix(input int base, input int r, input int c);
      return base + r * LINE + c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge reflect state cyc-1.
   task automatic step();
      int m, r, c, k, ea;
      bit vr, erc;
      @(posedge clk);
      #1;
      cyc++;
      if (!hsn) hs_low++;
      if (!fsn) fs_low++;
      if (fetch) fetch_n++;
      if (rowclear) rc_n++;
      if (frame_start) fs_n++;
      if (track_alpha) begin
         m   = cyc - 1;
         r   = m / LINE;
         c   = m % LINE;
         vr  = (r >= 12) && (r < 24);
         k   = (r - 12 + 1) % 4;
         ea  = vr ? k : 0;
         erc = vr && (c == 0) && (k == 0);
         if (alpha_row !== 4'(ea) || rowclear !== erc) alpha_bad++;
      end
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl.push_back('{0,   0,   pk(1,1,2'b00,0,0, 0,1,1)});
      tbl.push_back('{0,   11,  pk(0,1,2'b00,0,0, 0,0,0)});
      tbl.push_back('{0,   33,  pk(0,1,2'b00,0,0, 0,0,0)});
      tbl.push_back('{0,   34,  pk(1,1,2'b00,0,0, 0,0,0)});
      tbl.push_back('{4,   100, pk(1,0,2'b00,0,0, 0,0,0)});
      tbl.push_back('{7,   200, pk(1,0,2'b00,0,0, 0,0,0)});
      tbl.push_back('{8,   200, pk(1,1,2'b00,0,0, 0,0,0)});
      tbl.push_back('{10,  77,  pk(1,1,2'b00,0,0, 0,0,0)});
      tbl.push_back('{10,  78,  pk(1,1,2'b10,0,0, 0,0,0)});
      tbl.push_back('{11,  122, pk(1,1,2'b10,0,0, 0,0,0)});
      tbl.push_back('{12,  0,   pk(1,1,2'b00,0,0, 0,1,0)});
      tbl.push_back('{12,  122, pk(1,1,2'b10,1,0, 1,0,0)});
      tbl.push_back('{12,  123, pk(1,1,2'b10,0,0, 0,0,0)});
      tbl.push_back('{12,  130, pk(1,1,2'b11,1,1, 0,0,0)});
      tbl.push_back('{12,  370, pk(1,1,2'b11,1,31,0,0,0)});
      tbl.push_back('{12,  378, pk(1,1,2'b11,0,0, 0,0,0)});
      tbl.push_back('{12,  386, pk(1,1,2'b10,0,0, 0,0,0)});
      tbl.push_back('{23,  385, pk(1,1,2'b11,0,0, 0,0,0)});
      tbl.push_back('{24,  200, pk(1,1,2'b10,0,0, 0,0,0)});
      tbl.push_back('{29,  457, pk(1,1,2'b10,0,0, 0,0,0)});

      #23;
      check("reset_outputs", actual(), pk(1,1,2'b00,0,0,0,0,0));
      check("reset_misc", {alpha_row, rowclear, field, lp_x, lp_y, lp_valid}, '0);
      @(negedge clk);
      rstn = 1'b1;
      cyc  = 0;

      run_to(1);
      check("field_first_frame", field, 1);
      foreach (tbl[i]) begin
         run_to(ix(0, tbl[i].row, tbl[i].col) + 1);
         check($sformatf("vec%0d_r%0d_c%0d", i, tbl[i].row, tbl[i].col), actual(), tbl[i].exp);
      end
      check("hsn_low_clocks_f1", hs_low, 23 * VN);
      check("fsn_low_clocks_f1", fs_low, 4 * LINE);
      check("fetch_pulses_f1", fetch_n, 32 * 12);
      check("rowclear_pulses_f1", rc_n, 3);
      check("frame_starts_f1", fs_n, 1);
      check("alpha_track_f1", alpha_bad, 0);
      track_alpha = 1'b0;

      run_to(F2 + 1);
      check("f2_start", {line_start, frame_start, field}, 3'b110);

      // Mid-frame control change must not affect this frame.
      run_to(ix(F2, 10, 0));
      format = 1'b1;
      div2   = 1'b1;
      run_to(ix(F2, 13, 130) + 1);
      check("f2_still_ntsc_div1", {active, fetch, byte_idx}, {2'b11, 1'b1, 5'd1});

      run_to(ix(F2, 14, 198));
      check("lp_idle", lp_valid, 0);
      lp = 1'b1;
      run_to(ix(F2, 14, 198) + 3);
      check("lp_capture", {lp_valid, lp_x, lp_y}, {1'(LP), 8'(70 * LP), 8'(2 * LP)});
      run_to(ix(F2, 14, 198) + 6);
      lp = 1'b0;
      run_to(ix(F2, 14, 250));
      lp = 1'b1;
      run_to(ix(F2, 14, 250) + 4);
      check("lp_second_ignored", {lp_valid, lp_x, lp_y}, {1'(LP), 8'(70 * LP), 8'(2 * LP)});
      lp = 1'b0;
      run_to(ix(F2, 15, 0));
      lp_ack = 1'b1;
      run_to(ix(F2, 15, 0) + 1);
      lp_ack = 1'b0;
      check("lp_ack_clears", lp_valid, 0);
      run_to(ix(F2, 16, 198));
      lp = 1'b1;
      run_to(ix(F2, 16, 198) + 2);
      lp_ack = 1'b1;
      run_to(ix(F2, 16, 198) + 3);
      lp_ack = 1'b0;
      run_to(ix(F2, 16, 198) + 6);
      check("lp_ack_beats_edge", lp_valid, 0);
      lp = 1'b0;

      run_to(F3 + 1);
      check("f2_len_ntsc", {frame_start, field}, 2'b11);
      run_to(ix(F3, 12, 200) + 1);
      check("f3_pal_row12_border", active, 2'b10);
      run_to(ix(F3, 16, 0));
      fetch_n = 0;
      run_to(ix(F3, 16, 122) + 1);
      check("d2_fetch_k0", {active, fetch, byte_idx, preload}, {2'b10, 1'b1, 5'd0, 1'b1});
      run_to(ix(F3, 16, 130) + 1);
      check("d2_no_fetch_130", {active, fetch}, {2'b11, 1'b0});
      run_to(ix(F3, 16, 138) + 1);
      check("d2_fetch_k1", {fetch, byte_idx, preload}, {1'b1, 5'd1, 1'b0});
      run_to(ix(F3, 16, 362) + 1);
      check("d2_fetch_k15", {fetch, byte_idx}, {1'b1, 5'd15});
      run_to(ix(F3, 16, 378) + 1);
      check("d2_no_fetch_378", fetch, 0);
      run_to(ix(F3, 17, 0));
      check("d2_fetch_per_line", fetch_n, 16);

      run_to(ix(F3, 20, 199));
      lp = 1'b1;
      run_to(ix(F3, 20, 199) + 3);
      check("lp_capture_d2", {lp_valid, lp_x, lp_y}, {1'(LP), 8'(35 * LP), 8'(4 * LP)});
      lp = 1'b0;
      run_to(ix(F3, 27, 200) + 1);
      check("pal_last_view_row", active, 2'b11);
      run_to(ix(F3, 28, 200) + 1);
      check("pal_below_view", active, 2'b10);
      run_to(F3 + NF + 1);
      check("f3_not_ntsc_len", {line_start, frame_start}, 2'b10);
      run_to(F4 + 1);
      check("f3_len_pal", {frame_start, field}, 2'b10);

      run_to(ix(F4, 20, 200) + 1);
      check("pre_reset_state", {active, alpha_row}, {2'b11, 4'd1});
      #2;
      rstn = 1'b0;
      #1;
      check("async_reset_outputs", actual(), pk(1,1,2'b00,0,0,0,0,0));
      check("async_reset_misc", {alpha_row, rowclear, field, lp_x, lp_y, lp_valid}, '0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", {active, line_start}, '0);
      @(negedge clk);
      rstn = 1'b1;
      cyc  = 0;
      run_to(1);
      check("restart_origin", {line_start, frame_start, field}, 3'b111);
      run_to(ix(0, 12, 130) + 1);
      check("restart_shadow_cleared", {active, fetch, byte_idx}, {2'b11, 1'b1, 5'd1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
